// File: rtl/float_pkg.sv
// rtl/float_pkg.sv - shared constants, state encoding and word packing for the float normalizer
//
// Purpose : single-precision field limits, FSM state enum, result packing
//           helper and the signed zero / infinity encodings.
// Ports   : none (package).

package float_pkg;

  localparam logic [7:0] EXP_MAX  = 8'hFF;
  localparam int         EXP_BIAS = 127;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] NEG_ZERO = 32'h8000_0000;
  localparam logic [31:0] POS_INF  = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF  = 32'hFF80_0000;

  function automatic logic [31:0] pack(input logic       sign,
                                       input logic [7:0]  exp,
                                       input logic [22:0] frac);
    return {sign, exp, frac};
  endfunction

endpackage

// File: rtl/float_normalizer.sv
// rtl/float_normalizer.sv - iterative renormalizer from raw adder sum to IEEE-754 single
//
// Purpose : accepts one raw {sign, exp, 25-bit mantissa} operand, normalizes
//           it (carry right-shift or one-bit-per-cycle left shift), packs a
//           single-precision word and holds it until the consumer accepts it.
// Ports   : clk        clock, rising edge
//           rst        synchronous active-high reset
//           in_valid   raw operand present
//           in_ready   operand accepted (IDLE and not in reset)
//           in_sign    raw sign
//           in_exp     common exponent before carry adjustment
//           in_mant    raw sum; bit 24 carry-out, bit 23 hidden one
//           out_valid  registered result valid
//           out_ready  consumer accepts result
//           result     registered {sign, exp, frac}

module float_normalizer
  import float_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W-1:0]        in_exp,
  input  logic [FRAC_W+1:0]       in_mant,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   result
);

  // One extra exponent bit so the carry increment past 254 is visible.
  localparam logic [EXP_W:0] EXP_ONE = 1;

  state_e                 state_q;
  logic                   sign_q;
  logic [EXP_W:0]         exp_q;
  logic [FRAC_W+1:0]      mant_q;
  logic                   out_valid_q;
  logic [EXP_W+FRAC_W:0]  result_q;

  logic [EXP_W:0]         exp_inc;
  logic [EXP_W+FRAC_W:0]  zero_word;
  logic [EXP_W+FRAC_W:0]  inf_word;

  assign exp_inc   = exp_q + EXP_ONE;
  assign zero_word = sign_q ? NEG_ZERO : POS_ZERO;
  assign inf_word  = sign_q ? NEG_INF  : POS_INF;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign result    = result_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q  <= in_sign;
            exp_q   <= {1'b0, in_exp};
            mant_q  <= in_mant;
            state_q <= NORM;
          end
        end

        NORM: begin
          // Rules are checked in strict priority; only the last one loops.
          if (mant_q == '0) begin
            result_q    <= zero_word;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (exp_q == {1'b0, EXP_MAX}) begin
            result_q    <= inf_word;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (mant_q[FRAC_W+1]) begin
            // Carry-out: truncating right shift, so the fraction is mant[23:1].
            if (exp_inc >= {1'b0, EXP_MAX}) begin
              result_q <= inf_word;
            end else begin
              result_q <= pack(sign_q, exp_inc[EXP_W-1:0], mant_q[FRAC_W:1]);
            end
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (mant_q[FRAC_W]) begin
            result_q    <= pack(sign_q, exp_q[EXP_W-1:0], mant_q[FRAC_W-1:0]);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (exp_q <= EXP_ONE) begin
            // No denormal output: cancellation below exp 1 flushes to zero.
            result_q    <= zero_word;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            mant_q <= mant_q << 1;
            exp_q  <= exp_q - EXP_ONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/float_normalizer.md
# float_normalizer

Sequential normalization stage placed directly downstream of the combinational float adder. It accepts the adder's raw sign, common exponent and 25-bit unnormalized mantissa sum, and renormalizes it into an IEEE-754 single-precision word. Cancellation after subtraction is handled by an iterative one-bit-per-cycle left shift. Results are delivered over a valid/ready handshake so the adder's consumer can apply backpressure.

## Interface
- EXP_W, 8, exponent width; fixed for single precision.
- FRAC_W, 23, stored fraction width; the raw mantissa is FRAC_W+2 bits wide.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  raw operand present.
- in_ready  output  1  high only in IDLE with rst low.
- in_sign  input  1  sign of raw result.
- in_exp  input  8  common exponent from the adder, before any carry adjustment.
- in_mant  input  25  raw mantissa sum; bit 24 is carry-out, bit 23 is the hidden-one position.
- out_valid  output  1  registered; result is valid.
- out_ready  input  1  consumer accepts result.
- result  output  32  packed {sign, exp[7:0], frac[22:0]}; registered.

## Operation
- FSM states are IDLE, NORM and DONE. Reset state is IDLE, with out_valid=0 and result=32'h0.
- **IDLE:** an in_valid&in_ready edge captures sign, exp and mant into working registers and moves to NORM.
- **NORM** evaluates one rule per cycle, in this priority order:
  1. mant==0: result={sign,31'h0} (signed zero preserved), go to DONE.
  2. exp==8'hFF: result={sign,8'hFF,23'h0} (infinity), go to DONE.
  3. mant[24]=1: mant>>1 truncating, exp+1. If exp+1>=255 the result is infinity; otherwise pack {sign,exp+1,mant[23:1] after shift}. Go to DONE.
  4. mant[23]=1: pack {sign,exp,mant[22:0]}, go to DONE.
  5. exp<=1: underflow, flush to zero, result={sign,31'h0}, go to DONE. Denormals are not produced.
  6. Otherwise: mant<<=1, exp-=1, stay in NORM.
- **DONE:** out_valid=1 and result is held stable. An out_valid&out_ready edge moves to IDLE and clears out_valid. result keeps its last value.
- Only one operand is in flight; there is no overlap of accept and deliver.
- Rounding is truncation, consistent with the upstream adder.
- Arithmetic: exp is held in a 9-bit working register so the +1 overflow is detectable. The left-shift count is bounded at 23 because the nonzero mantissa reaches bit 23.

## Timing
- For an operand accepted at edge k that needs n left shifts, out_valid rises after edge k+1+n. n=0 gives 1-cycle latency; the maximum is 24 cycles.
- in_ready is 0 throughout NORM and DONE. in_valid during those states is ignored and not captured.
- Backpressure: in DONE with out_ready=0, out_valid and result are held indefinitely.
- out_ready high while out_valid is low has no effect.
- If in_valid is asserted in the cycle after a DONE→IDLE transition, it is accepted in that cycle, giving 1 idle cycle minimum between results.
- A rst mid-NORM or mid-DONE returns to IDLE on that edge. out_valid and result clear, and in_ready is 0 during the reset cycle. The in-flight operand is discarded.
- No combinational path from in_* to out_*. in_ready depends only on state and rst.

## Structure
- Shared package float_pkg holds:
  - EXP_MAX=8'hFF and EXP_BIAS=127;
  - the state enum {IDLE, NORM, DONE};
  - the pack function (sign, exp, frac → 32-bit word);
  - the constants for +/-zero and +/-infinity.
- No sub-module is needed; a single module with one FSM plus a datapath register block.

## Test plan
- sign0, exp 127, mant 25'h0800000 → result 32'h3F800000, out_valid 1 cycle after accept.
- sign0, exp 127, mant 25'h1000000 → result 32'h40000000 after 1 cycle (carry normalization).
- sign0, exp 150, mant 25'h0000001 → 23 shifts, result 32'h3F800000, out_valid exactly 24 cycles after accept.
- Boundaries:
  - sign1, mant 0, exp 100 → 32'h80000000.
  - sign0, exp 254, mant 25'h1000000 → 32'h7F800000.
  - sign1, exp 3, mant 25'h0000010 → underflow flush 32'h80000000.
- Handshake and reset:
  - Hold out_ready=0 for 10 cycles in DONE → result stable, in_ready=0, second in_valid ignored.
  - Assert rst during NORM → next cycle IDLE with out_valid=0 and result=0.
